time_alarm_core: RTL and testbench

- Timekeeping datapath directly downstream of the mode/alarm state machine.
- Consumes that FSM's mode enables (EN), adjust flag, debounced up/down pulses and snooze controls.
- Holds the time-of-day counters (HH:MM:SS) and the alarm setpoint (HH:MM).
- Returns the alarm-match flag Z, seconds count secs, and snooze-expiry z_s to the FSM.

---
 rtl/time_alarm_core.sv | 199 +++++++++++++++++++
 tb/tb_time_alarm_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_alarm_core.sv
// ---------------------------------------------------------------------------
// time_alarm_core
//
// Timekeeping datapath that sits below the mode/alarm state machine. It keeps
// the time of day (HH:MM:SS), the alarm setpoint (HH:MM) and a snooze
// counter. It reports the alarm match, the seconds count and the
// snooze-expiry pulse back to the state machine.
//
// Optional feature macro: TIME12_DISPLAY_EN
//   defined   : disp_hours/pm give a registered 12-hour view of hours
//               (reset value 12 / 0).
//   undefined : disp_hours mirrors hours combinationally and pm is 0.
//
// Ports
//   clk         system clock, all state updates on its rising edge
//   rst         synchronous active-high reset
//   clk_sec     one-cycle 1 Hz tick
//   EN[4:0]     [4] adj time hours, [3] adj time mins, [2] adj alarm hours,
//               [1] adj alarm mins, [0] time run
//   adjust      up/down are honoured only while this is 1
//   up, down    one-cycle increment / decrement pulses
//   snoozeEN    snooze counter counts clk_sec ticks while 1
//   snooze_rst  clears the snooze counter
//   hours, mins, secs       time of day
//   al_hours, al_mins       alarm setpoint
//   Z           registered alarm match (level)
//   z_s         one-cycle snooze-expiry pulse
//   disp_hours  display hour
//   pm          PM indicator
// ---------------------------------------------------------------------------
module time_alarm_core #(
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned SNZ_W       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_sec,
    input  logic [4:0] EN,
    input  logic       adjust,
    input  logic       up,
    input  logic       down,
    input  logic       snoozeEN,
    input  logic       snooze_rst,
    output logic [4:0] hours,
    output logic [5:0] mins,
    output logic [5:0] secs,
    output logic [4:0] al_hours,
    output logic [5:0] al_mins,
    output logic       Z,
    output logic       z_s,
    output logic [4:0] disp_hours,
    output logic       pm
);

    localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_SECS - 1);
    localparam logic [SNZ_W-1:0] SNZ_ONE  = SNZ_W'(1);

    // Modular +1 / -1 over 0..max_v; returns v when neither direction is set.
    function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                             input logic [5:0] max_v,
                                             input logic       inc,
                                             input logic       dec);
        if (inc)
            return (v == max_v) ? 6'd0 : v + 6'd1;
        else if (dec)
            return (v == 6'd0) ? max_v : v - 6'd1;
        else
            return v;
    endfunction

    logic [4:0]       hours_q, hours_d;
    logic [5:0]       mins_q, mins_d;
    logic [5:0]       secs_q, secs_d;
    logic [4:0]       al_hours_q, al_hours_d;
    logic [5:0]       al_mins_q, al_mins_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic             z_q;
    logic             zs_q, zs_d;

    logic inc, dec;
    logic t_sel_h, t_sel_m, a_sel_h, a_sel_m;
    logic t_adj_evt, tick;

    always_comb begin
        // up and down together cancel out.
        inc = up & ~down;
        dec = down & ~up;

        t_sel_h = adjust & EN[4];
        t_sel_m = adjust & ~EN[4] & EN[3];
        a_sel_h = adjust & EN[2];
        a_sel_m = adjust & ~EN[2] & EN[1];

        // Any pulse on a selected time field (even a cancelled up+down)
        // takes the cycle from the running clock, so the tick is dropped.
        t_adj_evt = (t_sel_h | t_sel_m) & (up | down);
        tick      = EN[0] & clk_sec & ~t_adj_evt;

        hours_d    = hours_q;
        mins_d     = mins_q;
        secs_d     = secs_q;
        al_hours_d = al_hours_q;
        al_mins_d  = al_mins_q;

        if (tick) begin
            // Full S -> M -> H carry chain resolves in one cycle.
            secs_d = wrap_step(secs_q, 6'd59, 1'b1, 1'b0);
            if (secs_q == 6'd59) begin
                mins_d = wrap_step(mins_q, 6'd59, 1'b1, 1'b0);
                if (mins_q == 6'd59)
                    hours_d = 5'(wrap_step({1'b0, hours_q}, 6'd23, 1'b1, 1'b0));
            end
        end else if (t_sel_h) begin
            hours_d = 5'(wrap_step({1'b0, hours_q}, 6'd23, inc, dec));
        end else if (t_sel_m) begin
            // Minute adjust never carries into hours; it restarts the minute.
            mins_d = wrap_step(mins_q, 6'd59, inc, dec);
            if (inc | dec)
                secs_d = 6'd0;
        end

        if (a_sel_h)
            al_hours_d = 5'(wrap_step({1'b0, al_hours_q}, 6'd23, inc, dec));
        else if (a_sel_m)
            al_mins_d = wrap_step(al_mins_q, 6'd59, inc, dec);

        snz_d = snz_q;
        zs_d  = 1'b0;
        if (snooze_rst) begin
            snz_d = '0;
        end else if (snoozeEN && clk_sec) begin
            if (snz_q == SNZ_LAST) begin
                snz_d = '0;
                zs_d  = 1'b1;
            end else begin
                snz_d = snz_q + SNZ_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hours_q    <= '0;
            mins_q     <= '0;
            secs_q     <= '0;
            al_hours_q <= '0;
            al_mins_q  <= '0;
            snz_q      <= '0;
            z_q        <= 1'b0;
            zs_q       <= 1'b0;
        end else begin
            hours_q    <= hours_d;
            mins_q     <= mins_d;
            secs_q     <= secs_d;
            al_hours_q <= al_hours_d;
            al_mins_q  <= al_mins_d;
            snz_q      <= snz_d;
            // Compared against the current registers, so Z trails a counter
            // change by one clock.
            z_q        <= (hours_q == al_hours_q) && (mins_q == al_mins_q);
            zs_q       <= zs_d;
        end
    end

    assign hours    = hours_q;
    assign mins     = mins_q;
    assign secs     = secs_q;
    assign al_hours = al_hours_q;
    assign al_mins  = al_mins_q;
    assign Z        = z_q;
    assign z_s      = zs_q;

`ifdef TIME12_DISPLAY_EN
    logic [4:0] disp_q;
    logic       pm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= 5'd12;
            pm_q   <= 1'b0;
        end else begin
            if (hours_q == 5'd0)
                disp_q <= 5'd12;
            else if (hours_q > 5'd12)
                disp_q <= hours_q - 5'd12;
            else
                disp_q <= hours_q;
            pm_q <= (hours_q >= 5'd12);
        end
    end

    assign disp_hours = disp_q;
    assign pm         = pm_q;
`else
    assign disp_hours = hours_q;
    assign pm         = 1'b0;
`endif

endmodule

// File: tb/tb_time_alarm_core.sv
// ---------------------------------------------------------------------------
// tb_time_alarm_core
//
// Directed bench for time_alarm_core with SNOOZE_SECS = 5. Each scenario task
// drives its stimulus and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_time_alarm_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_sec;
    logic [4:0] EN;
    logic       adjust;
    logic       up;
    logic       down;
    logic       snoozeEN;
    logic       snooze_rst;
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [4:0] al_hours;
    logic [5:0] al_mins;
    logic       Z;
    logic       z_s;
    logic [4:0] disp_hours;
    logic       pm;

    int passed = 0;
    int total  = 0;

    time_alarm_core #(
        .SNOOZE_SECS(5),
        .SNZ_W      (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_sec   (clk_sec),
        .EN        (EN),
        .adjust    (adjust),
        .up        (up),
        .down      (down),
        .snoozeEN  (snoozeEN),
        .snooze_rst(snooze_rst),
        .hours     (hours),
        .mins      (mins),
        .secs      (secs),
        .al_hours  (al_hours),
        .al_mins   (al_mins),
        .Z         (Z),
        .z_s       (z_s),
        .disp_hours(disp_hours),
        .pm        (pm)
    );

    always #5 clk = ~clk;

    // One clock with the given pulses applied; outputs are stable at return.
    task automatic step(input logic t, input logic u, input logic d);
        clk_sec = t;
        up      = u;
        down    = d;
        @(posedge clk);
        #1;
        clk_sec = 1'b0;
        up      = 1'b0;
        down    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic presses(input int n, input logic u);
        for (int i = 0; i < n; i++) step(1'b0, u, ~u);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (hours !== 5'd0) $display("FAIL reset_hours: got %0d want 0", hours); else passed++;
        total++; if (mins !== 6'd0) $display("FAIL reset_mins: got %0d want 0", mins); else passed++;
        total++; if (secs !== 6'd0) $display("FAIL reset_secs: got %0d want 0", secs); else passed++;
        total++; if (al_hours !== 5'd0 || al_mins !== 6'd0)
            $display("FAIL reset_alarm: got %0d:%0d want 0:0", al_hours, al_mins); else passed++;
        total++; if (Z !== 1'b0 || z_s !== 1'b0 || pm !== 1'b0)
            $display("FAIL reset_flags: got Z=%b z_s=%b pm=%b want 0 0 0", Z, z_s, pm); else passed++;
`ifdef TIME12_DISPLAY_EN
        total++; if (disp_hours !== 5'd12) $display("FAIL reset_disp: got %0d want 12", disp_hours); else passed++;
`else
        total++; if (disp_hours !== 5'd0) $display("FAIL reset_disp: got %0d want 0", disp_hours); else passed++;
`endif
        $display("test_reset: done");
    endtask

    task automatic test_rollover();
        adjust = 1'b1;
        EN = 5'b01000; presses(1, 1'b0);
        total++; if (mins !== 6'd59) $display("FAIL roll_mins_wrap: got %0d want 59", mins); else passed++;
        EN = 5'b10000; presses(1, 1'b0);
        total++; if (hours !== 5'd23) $display("FAIL roll_hours_wrap: got %0d want 23", hours); else passed++;
        adjust = 1'b0;
        EN = 5'b00001; ticks(59);
        total++; if ({hours, mins, secs} !== {5'd23, 6'd59, 6'd59})
            $display("FAIL roll_preset: got %0d:%0d:%0d want 23:59:59", hours, mins, secs); else passed++;
        ticks(1);
        total++; if ({hours, mins, secs} !== {5'd0, 6'd0, 6'd0})
            $display("FAIL roll_midnight: got %0d:%0d:%0d want 0:0:0", hours, mins, secs); else passed++;
        EN = 5'b00000; ticks(3);
        total++; if (secs !== 6'd0) $display("FAIL roll_freeze: got %0d want 0", secs); else passed++;
        $display("test_rollover: done");
    endtask

    task automatic test_adjust_wrap();
        adjust = 1'b1;
        EN = 5'b10000;
        presses(1, 1'b0);
        total++; if (hours !== 5'd23) $display("FAIL adj_hours_down: got %0d want 23", hours); else passed++;
        presses(1, 1'b1);
        total++; if (hours !== 5'd0) $display("FAIL adj_hours_up: got %0d want 0", hours); else passed++;
        step(1'b0, 1'b1, 1'b1);
        total++; if (hours !== 5'd0) $display("FAIL adj_up_down: got %0d want 0", hours); else passed++;
        adjust = 1'b0; presses(2, 1'b1);
        total++; if (hours !== 5'd0) $display("FAIL adj_disabled: got %0d want 0", hours); else passed++;
        EN = 5'b00001; ticks(37);
        total++; if (secs !== 6'd37) $display("FAIL adj_secs_preset: got %0d want 37", secs); else passed++;
        adjust = 1'b1; EN = 5'b01000; presses(1, 1'b1);
        total++; if (mins !== 6'd1 || secs !== 6'd0 || hours !== 5'd0)
            $display("FAIL adj_mins_clr_secs: got %0d:%0d:%0d want 0:1:0", hours, mins, secs); else passed++;
        // Tick and minute adjust together: adjust wins, tick dropped.
        EN = 5'b01001; step(1'b1, 1'b1, 1'b0);
        total++; if (mins !== 6'd2 || secs !== 6'd0)
            $display("FAIL adj_beats_tick: got %0d:%0d want 2:0", mins, secs); else passed++;
        adjust = 1'b0;
        $display("test_adjust_wrap: done");
    endtask

    task automatic test_alarm();
        adjust = 1'b1;
        EN = 5'b00101; presses(7, 1'b1);
        total++; if (al_hours !== 5'd7) $display("FAIL al_hours_set: got %0d want 7", al_hours); else passed++;
        EN = 5'b00011; presses(30, 1'b1);
        total++; if (al_mins !== 6'd30) $display("FAIL al_mins_set: got %0d want 30", al_mins); else passed++;
        EN = 5'b10000; presses(7, 1'b1);
        EN = 5'b01000; presses(27, 1'b1);
        adjust = 1'b0; EN = 5'b00001; ticks(59);
        total++; if ({hours, mins, secs} !== {5'd7, 6'd29, 6'd59} || Z !== 1'b0)
            $display("FAIL al_preset: got %0d:%0d:%0d Z=%b want 7:29:59 Z=0", hours, mins, secs, Z); else passed++;
        ticks(1);
        total++; if (mins !== 6'd30 || secs !== 6'd0 || Z !== 1'b0)
            $display("FAIL al_latency: got mins=%0d secs=%0d Z=%b want 30 0 0", mins, secs, Z); else passed++;
        step(1'b0, 1'b0, 1'b0);
        total++; if (Z !== 1'b1) $display("FAIL al_match: got Z=%b want 1", Z); else passed++;
        ticks(59);
        total++; if (Z !== 1'b1) $display("FAIL al_level: got Z=%b want 1", Z); else passed++;
        ticks(1);
        total++; if (mins !== 6'd31 || Z !== 1'b1)
            $display("FAIL al_fall_latency: got mins=%0d Z=%b want 31 1", mins, Z); else passed++;
        step(1'b0, 1'b0, 1'b0);
        total++; if (Z !== 1'b0) $display("FAIL al_fall: got Z=%b want 0", Z); else passed++;
        $display("test_alarm: done");
    endtask

    task automatic test_snooze();
        EN = 5'b00000; adjust = 1'b0;
        snooze_rst = 1'b1; step(1'b0, 1'b0, 1'b0); snooze_rst = 1'b0;
        snoozeEN = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ticks(1);
            total++; if (z_s !== (i == 5))
                $display("FAIL snz_tick%0d: got z_s=%b want %b", i, z_s, (i == 5)); else passed++;
        end
        step(1'b0, 1'b0, 1'b0);
        total++; if (z_s !== 1'b0) $display("FAIL snz_one_cycle: got z_s=%b want 0", z_s); else passed++;
        // Disabled counter holds at 0 across many ticks.
        snoozeEN = 1'b0; ticks(10);
        snoozeEN = 1'b1; ticks(3);
        snooze_rst = 1'b1; ticks(1); snooze_rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ticks(1);
            total++; if (z_s !== (i == 5))
                $display("FAIL snz_restart%0d: got z_s=%b want %b", i, z_s, (i == 5)); else passed++;
        end
        snoozeEN = 1'b0;
        $display("test_snooze: done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        adjust = 1'b1;
        EN = 5'b10000; presses(12, 1'b1);
        EN = 5'b01000; presses(34, 1'b1);
        adjust = 1'b0; EN = 5'b00001; ticks(56);
        EN = 5'b00000; snoozeEN = 1'b1; ticks(4);
        total++; if ({hours, mins, secs} !== {5'd12, 6'd34, 6'd56})
            $display("FAIL mid_preset: got %0d:%0d:%0d want 12:34:56", hours, mins, secs); else passed++;
        EN = 5'b00001; rst = 1'b1; ticks(1); rst = 1'b0; EN = 5'b00000;
        total++; if ({hours, mins, secs, al_hours, al_mins} !== '0 || Z !== 1'b0 || z_s !== 1'b0)
            $display("FAIL mid_reset: got %0d:%0d:%0d al %0d:%0d Z=%b z_s=%b want all 0",
                     hours, mins, secs, al_hours, al_mins, Z, z_s); else passed++;
`ifdef TIME12_DISPLAY_EN
        total++; if (disp_hours !== 5'd12 || pm !== 1'b0)
            $display("FAIL mid_disp: got %0d pm=%b want 12 0", disp_hours, pm); else passed++;
`else
        total++; if (disp_hours !== 5'd0 || pm !== 1'b0)
            $display("FAIL mid_disp: got %0d pm=%b want 0 0", disp_hours, pm); else passed++;
`endif
        for (int i = 1; i <= 5; i++) begin
            ticks(1);
            total++; if (z_s !== (i == 5))
                $display("FAIL mid_snz%0d: got z_s=%b want %b", i, z_s, (i == 5)); else passed++;
        end
        total++; if (Z !== 1'b1) $display("FAIL mid_zero_match: got Z=%b want 1", Z); else passed++;
        snoozeEN = 1'b0;
        $display("test_reset_mid: done");
    endtask

    task automatic test_display();
        do_reset();
        step(1'b0, 1'b0, 1'b0);
`ifdef TIME12_DISPLAY_EN
        total++; if (disp_hours !== 5'd12 || pm !== 1'b0)
            $display("FAIL disp_h0: got %0d pm=%b want 12 0", disp_hours, pm); else passed++;
        adjust = 1'b1; EN = 5'b10000; presses(12, 1'b1); step(1'b0, 1'b0, 1'b0);
        total++; if (disp_hours !== 5'd12 || pm !== 1'b1)
            $display("FAIL disp_h12: got %0d pm=%b want 12 1", disp_hours, pm); else passed++;
        presses(1, 1'b1); step(1'b0, 1'b0, 1'b0);
        total++; if (disp_hours !== 5'd1 || pm !== 1'b1)
            $display("FAIL disp_h13: got %0d pm=%b want 1 1", disp_hours, pm); else passed++;
        presses(10, 1'b1); step(1'b0, 1'b0, 1'b0);
        total++; if (disp_hours !== 5'd11 || pm !== 1'b1)
            $display("FAIL disp_h23: got %0d pm=%b want 11 1", disp_hours, pm); else passed++;
`else
        total++; if (disp_hours !== 5'd0 || pm !== 1'b0)
            $display("FAIL disp_h0: got %0d pm=%b want 0 0", disp_hours, pm); else passed++;
        adjust = 1'b1; EN = 5'b10000; presses(13, 1'b1);
        total++; if (disp_hours !== 5'd13 || pm !== 1'b0)
            $display("FAIL disp_h13: got %0d pm=%b want 13 0", disp_hours, pm); else passed++;
        presses(10, 1'b1);
        total++; if (disp_hours !== 5'd23 || pm !== 1'b0)
            $display("FAIL disp_h23: got %0d pm=%b want 23 0", disp_hours, pm); else passed++;
`endif
        adjust = 1'b0; EN = 5'b00000;
        $display("test_display: done");
    endtask

    initial begin
        rst = 1'b1; clk_sec = 1'b0; EN = 5'b00000; adjust = 1'b0;
        up = 1'b0; down = 1'b0; snoozeEN = 1'b0; snooze_rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rollover();
        test_adjust_wrap();
        test_alarm();
        test_snooze();
        test_reset_mid();
        test_display();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
